// File: rtl/multicycle_ctrl.sv
// Multicycle controller for an RV32 subset (R, I-arith, LW, SW, BEQ): FETCH/DECODE/EXEC/MEM/WB.
// Optional build macro MULTICYCLE_MEM_WAIT_EN stalls in MEM until dmem_ready is seen.
module multicycle_ctrl #(
  parameter int ALUW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            zero,
  input  logic            dmem_ready,
  output logic            PCSrc,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic            MemtoReg,
  output logic [ALUW-1:0] ALUCtrl,
  output logic            loadPC,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            illegal,
  output logic [2:0]      state
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5;
  } ir_t;

  // Registered control word; PCSrc and the SW loadPC are gated late by zero/dmem_ready.
  typedef struct packed {
    logic       pcsrc_en;
    logic       alusrc;
    logic       regwrite;
    logic       memtoreg;
    logic       loadpc;
    logic       memread;
    logic       memwrite;
    logic       illegal;
    logic [3:0] alu;
  } ctl_t;

  state_t state_q, state_d;
  ir_t    ir_q, ir_d;
  ctl_t   ctl_q;
  logic   mem_done;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // SLTU has no dedicated ALU code; it maps onto SLT.
  function automatic logic [3:0] alu_op(input ir_t ir);
    logic [3:0] a;
    a = ALU_ADD;
    if (ir.op == OP_BEQ) begin
      a = ALU_SUB;
    end else if (ir.op == OP_R || ir.op == OP_I) begin
      case (ir.f3)
        3'b000:  a = (ir.op == OP_R && ir.f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  a = ALU_SLL;
        3'b010:  a = ALU_SLT;
        3'b011:  a = ALU_SLT;
        3'b100:  a = ALU_XOR;
        3'b101:  a = ir.f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  a = ALU_OR;
        default: a = ALU_AND;
      endcase
    end
    return a;
  endfunction

  function automatic ctl_t decode(input state_t st, input ir_t ir);
    ctl_t c;
    logic is_i, is_lw, is_sw, is_beq;
    is_i   = (ir.op == OP_I);
    is_lw  = (ir.op == OP_LW);
    is_sw  = (ir.op == OP_SW);
    is_beq = (ir.op == OP_BEQ);
    c      = '0;
    c.alu  = ALU_ADD;
    case (st)
      DECODE: begin
        c.illegal = !is_legal(ir.op);
        c.loadpc  = !is_legal(ir.op);
      end
      EXEC: begin
        c.alu      = alu_op(ir);
        c.alusrc   = is_i | is_lw | is_sw;
        c.pcsrc_en = is_beq;
        c.loadpc   = is_beq;
      end
      MEM: begin
        c.memread  = is_lw;
        c.memwrite = is_sw;
        c.memtoreg = is_lw;
        c.loadpc   = is_sw;
      end
      WB: begin
        c.regwrite = 1'b1;
        c.memtoreg = is_lw;
        c.loadpc   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_done = dmem_ready;
`else
  logic unused_ready;
  assign unused_ready = dmem_ready;
  assign mem_done     = 1'b1;
`endif

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    state_d = FETCH;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
        ir_d    = {instr[6:0], instr[14:12], instr[30]};
      end
      DECODE: state_d = is_legal(ir_q.op) ? EXEC : FETCH;
      EXEC: begin
        if (ir_q.op == OP_R || ir_q.op == OP_I)        state_d = WB;
        else if (ir_q.op == OP_LW || ir_q.op == OP_SW) state_d = MEM;
        else                                           state_d = FETCH;
      end
      MEM: begin
        if (!mem_done)              state_d = MEM;
        else if (ir_q.op == OP_LW)  state_d = WB;
        else                        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      ctl_q   <= decode(FETCH, '0);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= decode(state_d, ir_d);
    end
  end

  assign state    = state_q;
  assign PCSrc    = ctl_q.pcsrc_en & zero;
  assign ALUSrc   = ctl_q.alusrc;
  assign RegWrite = ctl_q.regwrite;
  assign MemtoReg = ctl_q.memtoreg;
  assign ALUCtrl  = ALUW'(ctl_q.alu);
  assign loadPC   = ctl_q.loadpc & ((state_q != MEM) | mem_done);
  assign MemRead  = ctl_q.memread;
  assign MemWrite = ctl_q.memwrite;
  assign illegal  = ctl_q.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expectations, negedge monitor compares.
module tb_multicycle_ctrl;
  logic        clk, rst, zero, dmem_ready;
  logic [31:0] instr;
  logic        PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, MemRead, MemWrite, illegal;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;
  logic [7:0]  act_fl;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] st;
    logic [3:0] alu;
    logic [7:0] fl;
    string      tag;
  } exp_t;
  exp_t expq[$];

  // flag order: PCSrc ALUSrc RegWrite MemtoReg loadPC MemRead MemWrite illegal
  localparam logic [7:0] F_0     = 8'b00000000;
  localparam logic [7:0] F_EXSRC = 8'b01000000;
  localparam logic [7:0] F_WB    = 8'b00101000;
  localparam logic [7:0] F_WBLD  = 8'b00111000;
  localparam logic [7:0] F_MEMLD = 8'b00010100;
  localparam logic [7:0] F_SWW   = 8'b00000010;
  localparam logic [7:0] F_SWL   = 8'b00001010;
  localparam logic [7:0] F_BRT   = 8'b10001000;
  localparam logic [7:0] F_BRN   = 8'b00001000;
  localparam logic [7:0] F_ILL   = 8'b00001001;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;
  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_SRA = 4'b1010;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_SRAI = 32'h40325213;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00108463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  multicycle_ctrl #(.ALUW(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_ready(dmem_ready),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
    .illegal(illegal), .state(state)
  );

  assign act_fl = {PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, MemRead, MemWrite, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (state !== e.st || ALUCtrl !== e.alu || act_fl !== e.fl) begin
        failures++;
        $display("FAIL %s: got st=%0d alu=%b fl=%b, want st=%0d alu=%b fl=%b",
                 e.tag, state, ALUCtrl, act_fl, e.st, e.alu, e.fl);
      end
    end
  end

  task automatic expect_cyc(input logic [2:0] st, input logic [3:0] alu, input logic [7:0] fl,
                            input string tag);
    exp_t e;
    e.st = st; e.alu = alu; e.fl = fl; e.tag = tag;
    expq.push_back(e);
  endtask

  // Drive inputs for the cycle now starting, queue its expectation, advance to next cycle.
  task automatic step(input logic [31:0] ins, input logic z, input logic rdy,
                      input logic [2:0] st, input logic [3:0] alu, input logic [7:0] fl,
                      input string tag);
    instr = ins; zero = z; dmem_ready = rdy;
    expect_cyc(st, alu, fl, tag);
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic run_add(input string tag);
    step(I_ADD, 1'b0, 1'b1, S_F, A_ADD, F_0,  {tag, " fetch"});
    step(I_ADD, 1'b0, 1'b1, S_D, A_ADD, F_0,  {tag, " decode"});
    step(I_ADD, 1'b0, 1'b1, S_E, A_ADD, F_0,  {tag, " exec"});
    step(I_ADD, 1'b0, 1'b1, S_W, A_ADD, F_WB, {tag, " wb"});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; zero = 1'b0; dmem_ready = 1'b0; instr = 32'h0;
    @(posedge clk); #1;
    step(32'h0, 1'b1, 1'b0, S_F, A_ADD, F_0, "reset0");
    step(32'h0, 1'b1, 1'b0, S_F, A_ADD, F_0, "reset1");
    rst = 1'b0;

    run_add("add");

    step(I_SUB, 1'b0, 1'b1, S_F, A_ADD, F_0,  "sub fetch");
    step(I_SUB, 1'b0, 1'b1, S_D, A_ADD, F_0,  "sub decode");
    step(I_SUB, 1'b0, 1'b1, S_E, A_SUB, F_0,  "sub exec");
    step(I_SUB, 1'b0, 1'b1, S_W, A_ADD, F_WB, "sub wb");

    // addi with instr[30]=1 must stay ADD
    step(I_ADDI, 1'b0, 1'b1, S_F, A_ADD, F_0,     "addi fetch");
    step(I_ADDI, 1'b0, 1'b1, S_D, A_ADD, F_0,     "addi decode");
    step(I_ADDI, 1'b0, 1'b1, S_E, A_ADD, F_EXSRC, "addi exec");
    step(I_ADDI, 1'b0, 1'b1, S_W, A_ADD, F_WB,    "addi wb");

    step(I_SRAI, 1'b0, 1'b1, S_F, A_ADD, F_0,     "srai fetch");
    step(I_SRAI, 1'b0, 1'b1, S_D, A_ADD, F_0,     "srai decode");
    step(I_SRAI, 1'b0, 1'b1, S_E, A_SRA, F_EXSRC, "srai exec");
    step(I_SRAI, 1'b0, 1'b1, S_W, A_ADD, F_WB,    "srai wb");

    step(I_LW, 1'b0, 1'b0, S_F, A_ADD, F_0,     "lw fetch");
    step(I_LW, 1'b0, 1'b0, S_D, A_ADD, F_0,     "lw decode");
    step(I_LW, 1'b0, 1'b0, S_E, A_ADD, F_EXSRC, "lw exec");
`ifdef MULTICYCLE_MEM_WAIT_EN
    step(I_LW, 1'b0, 1'b0, S_M, A_ADD, F_MEMLD, "lw mem wait1");
    step(I_LW, 1'b0, 1'b0, S_M, A_ADD, F_MEMLD, "lw mem wait2");
    step(I_LW, 1'b0, 1'b1, S_M, A_ADD, F_MEMLD, "lw mem ready");
`else
    step(I_LW, 1'b0, 1'b0, S_M, A_ADD, F_MEMLD, "lw mem");
`endif
    step(I_LW, 1'b0, 1'b0, S_W, A_ADD, F_WBLD, "lw wb");

    step(I_SW, 1'b0, 1'b0, S_F, A_ADD, F_0,     "sw fetch");
    step(I_SW, 1'b0, 1'b0, S_D, A_ADD, F_0,     "sw decode");
    step(I_SW, 1'b0, 1'b0, S_E, A_ADD, F_EXSRC, "sw exec");
`ifdef MULTICYCLE_MEM_WAIT_EN
    step(I_SW, 1'b0, 1'b0, S_M, A_ADD, F_SWW,   "sw mem wait");
    step(I_SW, 1'b0, 1'b1, S_M, A_ADD, F_SWL,   "sw mem ready");
`else
    step(I_SW, 1'b0, 1'b0, S_M, A_ADD, F_SWL,   "sw mem");
`endif

    // zero held high throughout: PCSrc only in EXEC
    step(I_BEQ, 1'b1, 1'b1, S_F, A_ADD, F_0,   "beq-t fetch");
    step(I_BEQ, 1'b1, 1'b1, S_D, A_ADD, F_0,   "beq-t decode");
    step(I_BEQ, 1'b1, 1'b1, S_E, A_SUB, F_BRT, "beq-t exec");
    step(I_BEQ, 1'b0, 1'b1, S_F, A_ADD, F_0,   "beq-n fetch");
    step(I_BEQ, 1'b0, 1'b1, S_D, A_ADD, F_0,   "beq-n decode");
    step(I_BEQ, 1'b0, 1'b1, S_E, A_SUB, F_BRN, "beq-n exec");

    step(I_BAD, 1'b0, 1'b1, S_F, A_ADD, F_0,   "bad fetch");
    step(I_BAD, 1'b0, 1'b1, S_D, A_ADD, F_ILL, "bad decode");

    // reset pulsed during EXEC of a store
    step(I_SW, 1'b0, 1'b1, S_F, A_ADD, F_0, "swrst fetch");
    step(I_SW, 1'b0, 1'b1, S_D, A_ADD, F_0, "swrst decode");
    expect_cyc(S_E, A_ADD, F_EXSRC, "swrst exec");
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("swrst state",    32'(state),    32'd0);
    chk("swrst memwrite", 32'(MemWrite), 32'd0);
    chk("swrst loadpc",   32'(loadPC),   32'd0);
    chk("swrst alusrc",   32'(ALUSrc),   32'd0);
    chk("swrst aluctrl",  32'(ALUCtrl),  32'd2);
    @(posedge clk); #1;
    step(I_SW, 1'b0, 1'b1, S_F, A_ADD, F_0, "swrst held");
    rst = 1'b0;
    run_add("post-rst add");

    @(negedge clk); #1;
    chk("scoreboard drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter ALUW, default 4, giving the width of ALUCtrl.
REQ-002 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 The block SHALL have port instr, input, 32 bits, the current instruction word, valid in the FETCH state.
REQ-005 The block SHALL have port zero, input, 1 bit, the ALU zero flag from the datapath.
REQ-006 The block SHALL have port dmem_ready, input, 1 bit, the data-memory access-complete flag.
REQ-007 The block SHALL have ports PCSrc, ALUSrc, RegWrite and MemtoReg, each an output of 1 bit, as the datapath control strobes.
REQ-008 The block SHALL have port ALUCtrl, output, ALUW bits, the ALU operation select.
REQ-009 The block SHALL have port loadPC, output, 1 bit, the PC-update enable.
REQ-010 The block SHALL have ports MemRead and MemWrite, each an output of 1 bit, as the data-memory strobes.
REQ-011 The block SHALL have port illegal, output, 1 bit, a one-cycle pulse that flags an unsupported opcode.
REQ-012 The block SHALL have port state, output, 3 bits, the current FSM state encoding.

Function
REQ-013 The state encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5–7 SHALL go to FETCH on the next clock.
REQ-014 On the clock edge leaving FETCH, the FSM SHALL latch instr[6:0], instr[14:12] and instr[30] into an internal IR; all later decoding SHALL use the latched IR only.
REQ-015 The supported opcodes SHALL be R-type 0110011, I-arith 0010011, LW 0000011, SW 0100011 and BEQ 1100011.
REQ-016 Sequences SHALL be: R and I: FETCH, DECODE, EXEC, WB (4 cycles); LW: FETCH, DECODE, EXEC, MEM, WB (5 cycles); SW: FETCH, DECODE, EXEC, MEM (4 cycles); BEQ: FETCH, DECODE, EXEC (3 cycles).
REQ-017 Any other opcode SHALL make the FSM go DECODE to FETCH, pulse illegal for one cycle in DECODE, and assert loadPC in DECODE with PCSrc=0.
REQ-018 loadPC SHALL be 1 for exactly one cycle per instruction, in the final state of its sequence, and 0 at all other times.
REQ-019 ALUSrc SHALL be 1 in EXEC for I, LW and SW, and 0 for R and BEQ.
REQ-020 ALUCtrl encodings SHALL be AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.
REQ-021 ALUCtrl SHALL be chosen as follows: LW and SW use ADD; BEQ uses SUB; R-type decodes funct3 and instr[30]; I-type decodes funct3, with instr[30] honoured only for shifts.
REQ-022 PCSrc SHALL equal zero combinationally in EXEC when the IR holds BEQ, and SHALL be 0 otherwise.
REQ-023 MemRead (LW) and MemWrite (SW) SHALL be asserted only in MEM.
REQ-024 MemtoReg SHALL be 1 in MEM and WB for LW, and 0 otherwise.
REQ-025 RegWrite SHALL be 1 only in WB.
REQ-026 Outside EXEC, MEM and WB, the outputs ALUSrc, PCSrc, MemtoReg, MemRead, MemWrite and RegWrite SHALL all be 0, and ALUCtrl SHALL be 0010.

Reset
REQ-027 Asserting rst SHALL force, asynchronously: state=FETCH, IR=0, and PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, MemRead, MemWrite and illegal all 0, with ALUCtrl=0010.
REQ-028 A reset asserted mid-instruction SHALL abandon that instruction with no further loadPC, RegWrite or MemWrite.
REQ-029 After rst is released, the first state SHALL be FETCH.

Configuration
REQ-030 With macro MULTICYCLE_MEM_WAIT_EN defined, the FSM SHALL hold MEM, keeping its strobes asserted, while dmem_ready=0, and SHALL leave MEM on the first edge with dmem_ready=1.
REQ-031 When that exit happens in MEM for SW, loadPC SHALL be asserted only in the cycle where dmem_ready=1.
REQ-032 Without MULTICYCLE_MEM_WAIT_EN, MEM SHALL last exactly one cycle and dmem_ready SHALL be ignored.

Verification
REQ-033 Scenario: add x3,x1,x2 (0x002081B3). Required: states 0,1,2,4; ALUCtrl=0010 and ALUSrc=0 in EXEC; RegWrite=1 and loadPC=1 in WB only.
REQ-034 Scenario: lw x5,8(x0) (0x00802283), macro defined, dmem_ready low for 2 cycles. Required: MEM held 3 cycles with MemRead=1; WB then has MemtoReg=1 and RegWrite=1; total 7 cycles.
REQ-035 Scenario: beq x1,x1,+8 with zero=1. Required: EXEC has ALUCtrl=0110, PCSrc=1, loadPC=1; next state FETCH; total 3 cycles.
REQ-036 Scenario: opcode 0x7F. Required: illegal=1 and loadPC=1 in DECODE; RegWrite and MemWrite never asserted.
REQ-037 Scenario: sw x2,4(x1) (0x0020A223) with rst pulsed during EXEC. Required: MemWrite never asserted; state=0 immediately; next instruction starts cleanly.
REQ-038 Scenario: srai x4,x4,3 (0x40325213). Required: ALUCtrl=1010 and ALUSrc=1 in EXEC.
